picomips_seq_decoder: RTL and testbench

- Parametrised sequential successor to the picoMIPS combinational decoder, placed between program memory and the datapath (accumulator, register file, multiplier, PC).
- Keeps the same 8-bit opcode field map.
- Adds a switch synchroniser with debounce, a multi-cycle multiply stall, a wider register address and a post-reset settle state.
- Owns the PC hold decision: the PC advances only when this block permits it.

---
 rtl/picomips_seq_decoder.sv | 147 ++++++++++++++
 tb/tb_picomips_seq_decoder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/picomips_seq_decoder.sv
// Sequential picoMIPS instruction decoder: field decode, debounced switch wait,
// multi-cycle multiply stall and PC hold control for the datapath.
module picomips_seq_decoder #(
    parameter int n        = 8,
    parameter int Isize    = n + 8,
    parameter int NREG     = 4,
    parameter int MULLAT   = 2,
    parameter int SWSYNC   = 2,
    parameter int DEBOUNCE = 4,
    localparam int RA      = (NREG > 2) ? $clog2(NREG) : 1
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic [Isize-1:0] I,
    input  logic             SW8,
    output logic [n-1:0]     imm,
    output logic             PCHold,
    output logic             SelSW,
    output logic             SelImm,
    output logic             SelReg,
    output logic             UseMul,
    output logic             AccEn,
    output logic             AccRes,
    output logic             RegEn,
    output logic [RA-1:0]    RegAddr,
    output logic             Busy
);

    localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int MW = (MULLAT > 1) ? $clog2(MULLAT) : 1;
    localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE - 1);
    localparam logic [MW-1:0] MUL_LOAD = MW'((MULLAT > 0) ? MULLAT - 1 : 0);

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_RUN    = 2'd1,
        ST_MULW   = 2'd2
    } state_t;

    logic [7:0]        op;
    logic [SWSYNC-1:0] sync_q;
    logic              sw_s;
    logic              sw_prev_q;
    logic [DW-1:0]     db_cnt_q, db_cnt_d;
    logic              sw_valid_q, sw_valid_d;
    state_t            state_q, state_d;
    logic [MW-1:0]     mcnt_q, mcnt_d;
    logic              wait_c;
    logic              mul_c;

    assign op      = I[Isize-1:n];
    assign imm     = I[n-1:0];
    assign SelSW   = op[5];
    assign SelImm  = op[4];
    assign SelReg  = op[3];
    assign UseMul  = op[2];
    assign RegAddr = I[RA:1];
    assign Busy    = (state_q != ST_RUN);

    assign sw_s = sync_q[SWSYNC-1];

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            sync_q     <= '0;
            sw_prev_q  <= 1'b0;
            db_cnt_q   <= '0;
            sw_valid_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SWSYNC-2:0], SW8};
            sw_prev_q  <= sw_s;
            db_cnt_q   <= db_cnt_d;
            sw_valid_q <= sw_valid_d;
        end
    end

    // Any change in the synchronised level restarts the stability count.
    always_comb begin
        db_cnt_d   = db_cnt_q;
        sw_valid_d = sw_valid_q;
        if (sw_s != sw_prev_q) begin
            db_cnt_d = '0;
        end else begin
            if (db_cnt_q != DB_MAX) begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
            if (db_cnt_d == DB_MAX) begin
                sw_valid_d = sw_s;
            end
        end
    end

    assign wait_c = op[6] && (sw_valid_q == imm[0]);
    assign mul_c  = op[2] && op[1] && (MULLAT > 0);

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= ST_SETTLE;
            mcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            mcnt_q  <= mcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mcnt_d  = mcnt_q;
        PCHold  = 1'b1;
        AccEn   = 1'b0;
        AccRes  = 1'b0;
        RegEn   = 1'b0;
        case (state_q)
            ST_SETTLE: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // Switch wait outranks the multiply stall for the same instruction.
                if (wait_c) begin
                    state_d = ST_RUN;
                end else if (mul_c) begin
                    mcnt_d  = MUL_LOAD;
                    state_d = ST_MULW;
                end else begin
                    PCHold = 1'b0;
                    AccEn  = op[1];
                    AccRes = op[7];
                    RegEn  = op[0];
                end
            end
            ST_MULW: begin
                if (mcnt_q == '0) begin
                    PCHold  = 1'b0;
                    AccEn   = 1'b1;
                    AccRes  = op[7];
                    RegEn   = op[0];
                    state_d = ST_RUN;
                end else begin
                    mcnt_d = mcnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_SETTLE;
            end
        endcase
    end

endmodule

// File: tb/tb_picomips_seq_decoder.sv
// Directed self-checking bench for picomips_seq_decoder (default instance plus
// an NREG=8 / MULLAT=0 instance sharing the same inputs).
module tb_picomips_seq_decoder;

    logic        clk = 1'b0;
    logic        nReset;
    logic [15:0] I;
    logic        SW8;

    logic [7:0]  imm;
    logic        PCHold, SelSW, SelImm, SelReg, UseMul, AccEn, AccRes, RegEn, Busy;
    logic [1:0]  RegAddr;

    logic [7:0]  imm_8;
    logic        PCHold_8, SelSW_8, SelImm_8, SelReg_8, UseMul_8, AccEn_8, AccRes_8, RegEn_8, Busy_8;
    logic [2:0]  RegAddr_8;

    int n_chk = 0;
    int n_bad = 0;
    int cnt;
    logic mon_en = 1'b0;
    logic acc_seen = 1'b0;

    always #5 clk = ~clk;

    picomips_seq_decoder #(.n(8), .NREG(4), .MULLAT(2), .SWSYNC(2), .DEBOUNCE(4)) dut (
        .clk(clk), .nReset(nReset), .I(I), .SW8(SW8),
        .imm(imm), .PCHold(PCHold), .SelSW(SelSW), .SelImm(SelImm), .SelReg(SelReg),
        .UseMul(UseMul), .AccEn(AccEn), .AccRes(AccRes), .RegEn(RegEn),
        .RegAddr(RegAddr), .Busy(Busy)
    );

    picomips_seq_decoder #(.n(8), .NREG(8), .MULLAT(0), .SWSYNC(2), .DEBOUNCE(4)) dut8 (
        .clk(clk), .nReset(nReset), .I(I), .SW8(SW8),
        .imm(imm_8), .PCHold(PCHold_8), .SelSW(SelSW_8), .SelImm(SelImm_8), .SelReg(SelReg_8),
        .UseMul(UseMul_8), .AccEn(AccEn_8), .AccRes(AccRes_8), .RegEn(RegEn_8),
        .RegAddr(RegAddr_8), .Busy(Busy_8)
    );

    always @(AccEn) begin
        if (mon_en && AccEn) acc_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset release
        nReset = 1'b0;
        I      = 16'h0301;
        SW8    = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_pchold", PCHold, 1);
            chk("rst_regen", RegEn, 0);
            chk("rst_accen", AccEn, 0);
            chk("rst_busy", Busy, 1);
        end
        @(posedge clk);
        #1 nReset = 1'b1;
        @(negedge clk);
        chk("settle_pchold", PCHold, 1);
        chk("settle_regen", RegEn, 0);
        chk("settle_busy", Busy, 1);
        @(negedge clk);
        chk("run1_pchold", PCHold, 0);
        chk("run1_regen", RegEn, 1);
        chk("run1_accen", AccEn, 1);
        chk("run1_busy", Busy, 0);

        // switch wait
        I = 16'h4000;
        repeat (8) begin
            @(negedge clk);
            chk("wait_hold", PCHold, 1);
            chk("wait_accen", AccEn, 0);
        end
        SW8 = 1'b1;
        cnt = 0;
        while (PCHold && cnt < 50) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
        chk("wait_release_lat", cnt, 6);
        chk("wait_release_pchold", PCHold, 0);

        // bounce rejection: sw_valid is now 1, so imm[0]=1 waits
        I = 16'h4001;
        for (int k = 0; k < 20; k++) begin
            if (k % 2 == 0) SW8 = ~SW8;
            @(negedge clk);
            chk("bounce_hold", PCHold, 1);
        end
        repeat (10) begin
            @(negedge clk);
            chk("bounce_settled_hold", PCHold, 1);
        end

        // multiply stall
        I = 16'h8605;
        #1;
        chk("mul_c1_pchold", PCHold, 1);
        chk("mul_c1_accen", AccEn, 0);
        chk("mul_c1_busy", Busy, 0);
        chk("mul0_c1_pchold", PCHold_8, 0);
        chk("mul0_c1_accen", AccEn_8, 1);
        chk("mul0_c1_accres", AccRes_8, 1);
        @(negedge clk);
        chk("mul_c2_pchold", PCHold, 1);
        chk("mul_c2_accen", AccEn, 0);
        chk("mul_c2_busy", Busy, 1);
        @(negedge clk);
        chk("mul_c3_pchold", PCHold, 0);
        chk("mul_c3_accen", AccEn, 1);
        chk("mul_c3_accres", AccRes, 1);
        chk("mul_c3_regen", RegEn, 0);
        chk("mul_c3_busy", Busy, 1);
        I = 16'h0000;
        @(negedge clk);
        chk("mul_after_busy", Busy, 0);

        // reset during MULW
        I        = 16'h8605;
        acc_seen = 1'b0;
        mon_en   = 1'b1;
        @(negedge clk);
        chk("mulrst_in_mulw", Busy, 1);
        nReset = 1'b0;
        I      = 16'h0000;
        repeat (3) begin
            @(negedge clk);
            chk("mulrst_pchold", PCHold, 1);
            chk("mulrst_accen", AccEn, 0);
            chk("mulrst_busy", Busy, 1);
        end
        @(posedge clk);
        #1 nReset = 1'b1;
        @(negedge clk);
        chk("mulrst_settle_busy", Busy, 1);
        chk("mulrst_settle_pchold", PCHold, 1);
        @(negedge clk);
        chk("mulrst_run_busy", Busy, 0);
        mon_en = 1'b0;
        chk("mulrst_acc_seen", acc_seen, 0);

        // field passthrough
        I = 16'h390C;
        #2;
        chk("fld_regaddr8", RegAddr_8, 3'b110);
        chk("fld_regaddr4", RegAddr, 2'b10);
        chk("fld_selreg", SelReg_8, 1);
        chk("fld_selimm", SelImm_8, 1);
        chk("fld_selsw", SelSW_8, 1);
        chk("fld_regen", RegEn_8, 1);
        chk("fld_usemul", UseMul_8, 0);
        chk("fld_imm", imm_8, 8'h0C);
        chk("fld_pchold", PCHold_8, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
